// File: rtl/nx_nibble_alu_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract engine.
package nx_nibble_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB = 4;

  function automatic int unsigned round_up4(input int unsigned n);
    return ((n + NIB - 1) / NIB) * NIB;
  endfunction

  function automatic int unsigned nibbles(input int unsigned n);
    return round_up4(n) / NIB;
  endfunction

endpackage

// File: rtl/nx_nibble_alu_if.sv
// Operand/result handshake bundle for nx_nibble_alu.
interface nx_nibble_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic             co;
  logic             v;

  modport master (
    output in_valid, a, b, ci, bi, out_ready,
    input  in_ready, out_valid, y, x, co, v
  );

  modport slave (
    input  in_valid, a, b, ci, bi, out_ready,
    output in_ready, out_valid, y, x, co, v
  );
endinterface

// File: rtl/nx_nibble_alu_add4.sv
// Combinational 4-bit carry-chain slice exposing every per-bit carry out.
module nx_nibble_add4
  import nx_nibble_alu_pkg::*;
(
  input  logic [NIB-1:0] a4,
  input  logic [NIB-1:0] b4,
  input  logic           cin,
  output logic [NIB-1:0] s4,
  output logic [NIB-1:0] p4,
  output logic [NIB:1]   c
);
  localparam int unsigned SW = NIB + 1;

  logic [NIB:0] sum;

  assign p4  = a4 ^ b4;
  assign sum = SW'(a4) + SW'(b4) + SW'(cin);
  assign s4  = sum[NIB-1:0];
  // Carry into bit i is recovered as sum[i] ^ p[i]; the top carry is the sum MSB.
  assign c   = {sum[NIB], sum[NIB-1:1] ^ p4[NIB-1:1]};
endmodule

// File: rtl/nx_nibble_alu.sv
// Time-folded WIDTH-bit add/subtract: one 4-bit slice reused per clock, carry held in cr.
module nx_nibble_alu
  import nx_nibble_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  nx_nibble_alu_if.slave bus
);
  localparam int unsigned NW      = round_up4(WIDTH);
  localparam int unsigned N       = nibbles(WIDTH);
  localparam int unsigned KW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MSB_BIT = (WIDTH - 1) % NIB;

  state_t          state, state_n;
  logic [KW-1:0]   k;
  logic            cr;
  logic [NW-1:0]   opa, opb, y_sh, x_sh;
  logic            co_q, v_q, out_valid_q;
  logic [WIDTH-1:0] b_eff;
  logic [NIB-1:0]  s4, p4, c4;
  logic [NIB:0]    cfull;
  logic            accept, last, out_valid_n;

  assign b_eff = bus.bi ? ~bus.b : bus.b;
  assign cfull = {c4, cr};

  nx_nibble_add4 u_slice (
    .a4  (opa[NIB-1:0]),
    .b4  (opb[NIB-1:0]),
    .cin (cr),
    .s4  (s4),
    .p4  (p4),
    .c   (c4)
  );

  // Next-state and control decode.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    last        = 1'b0;
    out_valid_n = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        last = (k == KW'(N - 1));
        if (last) state_n = DONE;
      end
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    out_valid_n = (state_n == DONE);
  end

  // Operands shift down one nibble per RUN cycle; results shift in from the top,
  // so after N cycles nibble 0 lands in bits [3:0] and pad nibbles sit above WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      k           <= '0;
      cr          <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      y_sh        <= '0;
      x_sh        <= '0;
      co_q        <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state       <= state_n;
      out_valid_q <= out_valid_n;
      if (accept) begin
        opa <= NW'(bus.a);
        opb <= NW'(b_eff);
        cr  <= bus.ci;
        k   <= '0;
      end else if (state == RUN) begin
        opa  <= opa >> NIB;
        opb  <= opb >> NIB;
        cr   <= c4[NIB-1];
        k    <= k + KW'(1);
        y_sh <= NW'({s4, y_sh} >> NIB);
        x_sh <= NW'({p4, x_sh} >> NIB);
        // The MSB nibble is always the last; pick carries at bit WIDTH-1, not the slice top.
        if (last) begin
          co_q <= cfull[MSB_BIT+1];
          v_q  <= cfull[MSB_BIT+1] ^ cfull[MSB_BIT];
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_sh[WIDTH-1:0];
  assign bus.x         = x_sh[WIDTH-1:0];
  assign bus.co        = co_q;
  assign bus.v         = v_q;
endmodule

// File: tb/tb_nx_nibble_alu.sv
// Randomized and directed checks of nx_nibble_alu at WIDTH = 6, 8 and 32 against an arithmetic model.
module tb_nx_nibble_alu;
  import nx_nibble_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  nx_nibble_alu_if #(.WIDTH(6))  if6  ();
  nx_nibble_alu_if #(.WIDTH(8))  if8  ();
  nx_nibble_alu_if #(.WIDTH(32)) if32 ();

  nx_nibble_alu #(.WIDTH(6))  u_dut6  (.clk(clk), .rst_n(rst_n), .bus(if6));
  nx_nibble_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  nx_nibble_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain wide-integer arithmetic on the spec's definitions.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit ci, input bit bi,
                                output logic [31:0] y, output logic [31:0] x,
                                output bit co, output bit v);
    longint unsigned mask, m1, aa, bb, full, lo;
    mask = (64'd1 << w) - 64'd1;
    aa   = 64'(a) & mask;
    bb   = 64'(b) & mask;
    if (bi) bb = ~bb & mask;
    full = aa + bb + 64'(ci);
    y    = 32'(full & mask);
    x    = 32'((aa ^ bb) & mask);
    co   = 1'(full >> w);
    m1   = mask >> 1;
    lo   = (aa & m1) + (bb & m1) + 64'(ci);
    v    = co ^ 1'(lo >> (w - 1));
  endfunction

  task automatic set_in(input int w, input bit vld, input logic [31:0] a, input logic [31:0] b,
                        input bit ci, input bit bi);
    case (w)
      6: begin if6.in_valid = vld; if6.a = a[5:0]; if6.b = b[5:0]; if6.ci = ci; if6.bi = bi; end
      8: begin if8.in_valid = vld; if8.a = a[7:0]; if8.b = b[7:0]; if8.ci = ci; if8.bi = bi; end
      default: begin if32.in_valid = vld; if32.a = a; if32.b = b; if32.ci = ci; if32.bi = bi; end
    endcase
  endtask

  task automatic set_ready(input int w, input bit r);
    case (w)
      6: if6.out_ready = r;
      8: if8.out_ready = r;
      default: if32.out_ready = r;
    endcase
  endtask

  function automatic bit in_ready_of(input int w);
    case (w) 6: return if6.in_ready; 8: return if8.in_ready; default: return if32.in_ready; endcase
  endfunction
  function automatic bit out_valid_of(input int w);
    case (w) 6: return if6.out_valid; 8: return if8.out_valid; default: return if32.out_valid; endcase
  endfunction
  function automatic logic [31:0] y_of(input int w);
    case (w) 6: return 32'(if6.y); 8: return 32'(if8.y); default: return if32.y; endcase
  endfunction
  function automatic logic [31:0] x_of(input int w);
    case (w) 6: return 32'(if6.x); 8: return 32'(if8.x); default: return if32.x; endcase
  endfunction
  function automatic bit co_of(input int w);
    case (w) 6: return if6.co; 8: return if8.co; default: return if32.co; endcase
  endfunction
  function automatic bit v_of(input int w);
    case (w) 6: return if6.v; 8: return if8.v; default: return if32.v; endcase
  endfunction

  // One transaction: accept, measure latency, hold under backpressure, release, check IDLE retention.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit ci,
                       input bit bi, input int hold, input bit intrude);
    logic [31:0] ey, ex;
    bit eco, ev;
    int cyc;
    string t;
    model(w, a, b, ci, bi, ey, ex, eco, ev);
    t = $sformatf("w%0d a=%0h b=%0h ci=%0d bi=%0d", w, a, b, ci, bi);
    check({t, " in_ready_idle"}, 64'(in_ready_of(w)), 64'd1);
    set_in(w, 1'b1, a, b, ci, bi);
    @(posedge clk); #1;
    set_in(w, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
    check({t, " in_ready_busy"}, 64'(in_ready_of(w)), 64'd0);
    cyc = 0;
    while (!out_valid_of(w) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({t, " latency"}, 64'(cyc), 64'(nibbles(w)));
    for (int h = 0; h <= hold; h++) begin
      check({t, " y"},  64'(y_of(w)),  64'(ey));
      check({t, " x"},  64'(x_of(w)),  64'(ex));
      check({t, " co"}, 64'(co_of(w)), 64'(eco));
      check({t, " v"},  64'(v_of(w)),  64'(ev));
      if (h > 0) begin
        check({t, " out_valid_held"}, 64'(out_valid_of(w)), 64'd1);
        check({t, " in_ready_held"},  64'(in_ready_of(w)),  64'd0);
      end
      if (intrude && h == 0) set_in(w, 1'b1, ~a, a, ~ci, ~bi);
      @(posedge clk); #1;
    end
    set_in(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_ready(w, 1'b1);
    @(posedge clk); #1;
    set_ready(w, 1'b0);
    check({t, " out_valid_drop"}, 64'(out_valid_of(w)), 64'd0);
    check({t, " in_ready_back"},  64'(in_ready_of(w)),  64'd1);
    check({t, " y_retained"},     64'(y_of(w)),         64'(ey));
  endtask

  function automatic logic [31:0] pick(input logic [31:0] mask);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return mask;
      2: return mask >> 1;
      3: return (mask >> 1) + 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  initial begin
    int widths[3];
    int w;
    logic [31:0] mask;
    bit seen_valid;
    widths = '{6, 8, 32};
    rst_n = 1'b0;
    foreach (widths[i]) begin
      set_in(widths[i], 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      set_ready(widths[i], 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    foreach (widths[i]) begin
      check($sformatf("reset w%0d in_ready", widths[i]),  64'(in_ready_of(widths[i])),  64'd1);
      check($sformatf("reset w%0d out_valid", widths[i]), 64'(out_valid_of(widths[i])), 64'd0);
      check($sformatf("reset w%0d y", widths[i]),         64'(y_of(widths[i])),         64'd0);
      check($sformatf("reset w%0d x", widths[i]),         64'(x_of(widths[i])),         64'd0);
      check($sformatf("reset w%0d co", widths[i]),        64'(co_of(widths[i])),        64'd0);
      check($sformatf("reset w%0d v", widths[i]),         64'(v_of(widths[i])),         64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8, 32'h3C, 32'h05, 1'b0, 1'b0, 0, 1'b0);
    do_op(8, 32'h05, 32'h06, 1'b1, 1'b1, 1, 1'b0);
    do_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 0, 1'b0);
    check("ovf add v const", 64'(v_of(8)), 64'd1);
    do_op(8, 32'h80, 32'h01, 1'b1, 1'b1, 0, 1'b0);
    check("ovf sub co const", 64'(co_of(8)), 64'd1);
    do_op(6, 32'h3F, 32'h01, 1'b0, 1'b0, 0, 1'b0);
    check("pad co const", 64'(co_of(6)), 64'd1);
    do_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      w    = widths[$urandom_range(0, 2)];
      mask = 32'((64'd1 << w) - 64'd1);
      do_op(w, pick(mask), pick(mask), 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    // Leave a nonzero result, then reset in the third RUN cycle of the next op.
    do_op(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, 1'b0);
    set_in(32, 1'b1, 32'h8765_4321, 32'h0F0F_0F0F, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset out_valid", 64'(out_valid_of(32)), 64'd0);
    check("midrun_reset in_ready",  64'(in_ready_of(32)),  64'd1);
    check("midrun_reset y",         64'(y_of(32)),         64'd0);
    check("midrun_reset co",        64'(co_of(32)),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid_of(32)) seen_valid = 1'b1;
    end
    check("midrun_reset no_pulse", 64'(seen_valid), 64'd0);
    do_op(32, 32'd2, 32'd3, 1'b0, 1'b0, 0, 1'b0);
    check("after_reset y const", 64'(y_of(32)), 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
